// File: rtl/ts_null_stuffer_pkg.sv
// ts_null_stuffer_pkg
// Shared constants and types for the TS null stuffer:
//   TS_PKT_LEN / TS_LAST_IDX : TS packet length and index of its last byte
//   TS_SYNC                  : TS sync byte
//   NULL_PID and NULL_HDR*   : header bytes of a null packet
//   wr_state_t               : write-side state encoding
//   null_byte()              : null-packet byte ROM
package ts_null_stuffer_pkg;

  localparam int         TS_PKT_LEN  = 188;
  localparam logic [7:0] TS_LAST_IDX = 8'(TS_PKT_LEN - 1);
  localparam logic [7:0] TS_SYNC     = 8'h47;
  localparam logic [12:0] NULL_PID   = 13'h1FFF;

  // Header bytes 1..3 of a null packet: PID split over bytes 1/2,
  // payload-only adaptation control with CC=0 in byte 3.
  localparam logic [7:0] NULL_HDR1 = {3'b000, NULL_PID[12:8]};
  localparam logic [7:0] NULL_HDR2 = NULL_PID[7:0];
  localparam logic [7:0] NULL_HDR3 = 8'h10;
  localparam logic [7:0] NULL_FILL = 8'hFF;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // Byte idx of a null packet.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = TS_SYNC;
      8'd1:    b = NULL_HDR1;
      8'd2:    b = NULL_HDR2;
      8'd3:    b = NULL_HDR3;
      default: b = NULL_FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_packet_ram.sv
// ts_packet_ram
// Simple dual-port byte RAM: one write port, one registered read port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates the cycle after rd_en
//   rd_data           : registered read data, holds while rd_en is low
module ts_packet_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_r [0:(1 << ADDR_W) - 1];
  logic [7:0] rd_data_r;

  // Write port; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= 8'h00;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/ts_null_stuffer.sv
// ts_null_stuffer
// Buffers whole 188-byte T2-MI TS packets from the packer and emits a
// continuous packet-aligned TS, one byte per OUT_EN slot, inserting null
// packets (PID 0x1FFF) at packet boundaries when nothing complete is buffered.
// Ports:
//   CLK, RST            : byte clock, synchronous active-high reset
//   DATA_IN/ENA_IN/PSYNC_IN : input byte stream, PSYNC_IN marks byte 0
//   OUT_EN              : output byte slot strobe
//   DATA_OUT/ENA_OUT/PSYNC_OUT : output stream, one cycle after OUT_EN
//   OVERFLOW            : pulse when an incoming packet is dropped (buffer full)
//   SYNC_ERR            : pulse when a partial input packet is aborted
// Optional build macro TS_STUFFER_STATS_EN adds saturating counters
//   NULL_CNT[31:0] (null packets started) and DROP_CNT[15:0] (OVERFLOW events).
module ts_null_stuffer
  import ts_null_stuffer_pkg::*;
#(
  parameter int PKT_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       ENA_IN,
  input  logic       PSYNC_IN,
  input  logic       OUT_EN,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PSYNC_OUT,
  output logic       OVERFLOW,
  output logic       SYNC_ERR
`ifdef TS_STUFFER_STATS_EN
  ,
  output logic [31:0] NULL_CNT,
  output logic [15:0] DROP_CNT
`endif
);

  localparam int SLOT_W = $clog2(PKT_DEPTH);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int ADDR_W = SLOT_W + 8;
  localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(PKT_DEPTH);

  wr_state_t         wr_state_r;
  logic [7:0]        wr_cnt_r;
  logic [SLOT_W-1:0] wr_slot_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic              sync_err_r;

  logic [7:0]        rd_cnt_r;
  logic [SLOT_W-1:0] rd_slot_r;
  logic              rd_is_data_r;
  logic              sel_data_r;
  logic [7:0]        null_q_r;
  logic              ena_out_r;
  logic              psync_out_r;

  logic              full_s;
  logic              start_s;
  logic              commit_s;
  logic              release_s;
  logic              src_data_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_en_s;
  logic [7:0]        ram_q_s;

  assign full_s    = (count_r == CNT_FULL);
  // A sync byte restarts packet capture from any write state.
  assign start_s   = ENA_IN & PSYNC_IN;
  assign commit_s  = ENA_IN & ~PSYNC_IN & (wr_state_r == WR_FILL) & (wr_cnt_r == TS_LAST_IDX);
  assign release_s = OUT_EN & src_data_s & (rd_cnt_r == TS_LAST_IDX);
  assign wr_en_s   = (start_s & ~full_s) | (ENA_IN & ~PSYNC_IN & (wr_state_r == WR_FILL));
  assign wr_addr_s = {wr_slot_r, (start_s ? 8'd0 : wr_cnt_r)};
  assign rd_addr_s = {rd_slot_r, rd_cnt_r};
  assign rd_en_s   = OUT_EN & src_data_s;

  // Source for the current output byte: decided at the packet boundary from
  // the pre-commit count, then held for the rest of the packet.
  always_comb begin
    src_data_s = rd_is_data_r;
    if (rd_cnt_r == 8'd0) begin
      src_data_s = (count_r != {CNT_W{1'b0}});
    end else begin
      src_data_s = rd_is_data_r;
    end
  end

  // Write-side FSM: capture, drop and abort handling.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_state_r <= WR_IDLE;
      wr_cnt_r   <= 8'd0;
      wr_slot_r  <= {SLOT_W{1'b0}};
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
      if (start_s) begin
        // A sync byte mid-fill means the previous packet was short.
        if (wr_state_r == WR_FILL) begin
          sync_err_r <= 1'b1;
        end
        wr_cnt_r <= 8'd1;
        if (full_s) begin
          wr_state_r <= WR_DROP;
          overflow_r <= 1'b1;
        end else begin
          wr_state_r <= WR_FILL;
        end
      end else if (ENA_IN) begin
        case (wr_state_r)
          WR_FILL: begin
            if (wr_cnt_r == TS_LAST_IDX) begin
              wr_state_r <= WR_IDLE;
              wr_cnt_r   <= 8'd0;
              wr_slot_r  <= wr_slot_r + SLOT_ONE;
            end else begin
              wr_cnt_r <= wr_cnt_r + 8'd1;
            end
          end
          WR_DROP: begin
            if (wr_cnt_r == TS_LAST_IDX) begin
              wr_state_r <= WR_IDLE;
              wr_cnt_r   <= 8'd0;
            end else begin
              wr_cnt_r <= wr_cnt_r + 8'd1;
            end
          end
          WR_IDLE: begin
            wr_state_r <= WR_IDLE;
          end
          default: begin
            wr_state_r <= WR_IDLE;
            wr_cnt_r   <= 8'd0;
          end
        endcase
      end
    end
  end

  // Buffered packet count; simultaneous commit and release cancel out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({commit_s, release_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Read side: byte position, slot release and registered output controls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_cnt_r     <= 8'd0;
      rd_slot_r    <= {SLOT_W{1'b0}};
      rd_is_data_r <= 1'b0;
      sel_data_r   <= 1'b0;
      null_q_r     <= 8'h00;
      ena_out_r    <= 1'b0;
      psync_out_r  <= 1'b0;
    end else begin
      ena_out_r   <= OUT_EN;
      psync_out_r <= OUT_EN & (rd_cnt_r == 8'd0);
      if (OUT_EN) begin
        sel_data_r   <= src_data_s;
        null_q_r     <= null_byte(rd_cnt_r);
        rd_is_data_r <= src_data_s;
        rd_cnt_r     <= (rd_cnt_r == TS_LAST_IDX) ? 8'd0 : (rd_cnt_r + 8'd1);
        if (release_s) begin
          rd_slot_r <= rd_slot_r + SLOT_ONE;
        end
      end
    end
  end

  ts_packet_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (DATA_IN),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (ram_q_s)
  );

  // Both mux inputs and the select are registers, so DATA_OUT holds on stalls.
  assign DATA_OUT  = sel_data_r ? ram_q_s : null_q_r;
  assign ENA_OUT   = ena_out_r;
  assign PSYNC_OUT = psync_out_r;
  assign OVERFLOW  = overflow_r;
  assign SYNC_ERR  = sync_err_r;

`ifdef TS_STUFFER_STATS_EN
  logic [31:0] null_cnt_r;
  logic [15:0] drop_cnt_r;

  // Saturating statistics counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      null_cnt_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (OUT_EN && (rd_cnt_r == 8'd0) && !src_data_s && (null_cnt_r != 32'hFFFF_FFFF)) begin
        null_cnt_r <= null_cnt_r + 32'd1;
      end
      if (overflow_r && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign NULL_CNT = null_cnt_r;
  assign DROP_CNT = drop_cnt_r;
`endif

endmodule

// File: tb/tb_ts_null_stuffer.sv
// tb_ts_null_stuffer
// Randomized bench for ts_null_stuffer. A packet-level reference model
// (queues of bytes) predicts every output byte and every flag pulse; a
// separate monitor compares the DUT against those predictions.
module tb_ts_null_stuffer;

  localparam int DEPTH = 4;
  localparam int PLEN  = 188;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DATA_IN = 8'h00;
  logic       ENA_IN = 1'b0;
  logic       PSYNC_IN = 1'b0;
  logic       OUT_EN = 1'b0;
  logic [7:0] DATA_OUT;
  logic       ENA_OUT;
  logic       PSYNC_OUT;
  logic       OVERFLOW;
  logic       SYNC_ERR;
`ifdef TS_STUFFER_STATS_EN
  logic [31:0] NULL_CNT;
  logic [15:0] DROP_CNT;
`endif

  ts_null_stuffer #(.PKT_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .ENA_IN    (ENA_IN),
    .PSYNC_IN  (PSYNC_IN),
    .OUT_EN    (OUT_EN),
    .DATA_OUT  (DATA_OUT),
    .ENA_OUT   (ENA_OUT),
    .PSYNC_OUT (PSYNC_OUT),
    .OVERFLOW  (OVERFLOW),
    .SYNC_ERR  (SYNC_ERR)
`ifdef TS_STUFFER_STATS_EN
    ,
    .NULL_CNT  (NULL_CNT),
    .DROP_CNT  (DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [7:0] d; logic ps; } src_t;
  typedef struct { logic [7:0] b; logic ps; } out_t;
  typedef struct { logic rst; logic ena; logic ovf; logic serr; } flag_t;

  src_t  src_q[$];   // input bytes waiting to be driven
  out_t  data_q[$];  // expected output bytes
  flag_t flag_q[$];  // expected per-cycle flags

  // Reference model state
  logic [7:0] pkt_q[$];   // complete buffered packets, concatenated
  logic [7:0] asm_q[$];   // packet being assembled
  logic [7:0] cur [PLEN];
  int  pos = 0;
  bit  rd_active = 0;
  bit  cur_null = 1;
  int  wmode = 0;         // 0 idle, 1 filling, 2 dropping
  int  dropn = 0;
  int  m_null = 0;
  int  m_drop = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] null_ref(input int p);
    logic [7:0] hdr [4];
    hdr = '{8'h47, 8'h1F, 8'hFF, 8'h10};
    return (p < 4) ? hdr[p] : 8'hFF;
  endfunction

  // Advance the model by one clock using the inputs just driven.
  task automatic model_step();
    bit    full, avail;
    flag_t f;
    out_t  o;
    full  = ((pkt_q.size() / PLEN) + (rd_active ? 1 : 0)) == DEPTH;
    avail = pkt_q.size() >= PLEN;
    f.rst = 1'b0; f.ena = OUT_EN; f.ovf = 1'b0; f.serr = 1'b0;
    if (OUT_EN) begin
      if (pos == 0) begin
        if (avail) begin
          for (int i = 0; i < PLEN; i++) cur[i] = pkt_q.pop_front();
          rd_active = 1; cur_null = 0;
        end else begin
          cur_null = 1; m_null++;
        end
      end
      o.b  = cur_null ? null_ref(pos) : cur[pos];
      o.ps = (pos == 0);
      data_q.push_back(o);
      pos++;
      if (pos == PLEN) begin pos = 0; rd_active = 0; end
    end
    if (ENA_IN) begin
      if (PSYNC_IN) begin
        if (wmode == 1) f.serr = 1'b1;
        asm_q.delete();
        if (full) begin wmode = 2; dropn = 1; f.ovf = 1'b1; m_drop++; end
        else begin wmode = 1; asm_q.push_back(DATA_IN); end
      end else if (wmode == 1) begin
        asm_q.push_back(DATA_IN);
        if (asm_q.size() == PLEN) begin
          foreach (asm_q[i]) pkt_q.push_back(asm_q[i]);
          asm_q.delete();
          wmode = 0;
        end
      end else if (wmode == 2) begin
        dropn++;
        if (dropn == PLEN) wmode = 0;
      end
    end
    flag_q.push_back(f);
  endtask

  task automatic tick(input logic oe, input int ena_pct);
    src_t s;
    @(negedge CLK);
    RST = 1'b0; OUT_EN = oe; ENA_IN = 1'b0; PSYNC_IN = 1'b0; DATA_IN = 8'($urandom);
    if (src_q.size() > 0 && int'($urandom_range(99, 0)) < ena_pct) begin
      s = src_q.pop_front();
      ENA_IN = 1'b1; DATA_IN = s.d; PSYNC_IN = s.ps;
    end
    model_step();
  endtask

  task automatic do_reset();
    flag_t f;
    @(negedge CLK);
    RST = 1'b1; ENA_IN = 1'b0; PSYNC_IN = 1'b0; OUT_EN = 1'($urandom);
    f.rst = 1'b1; f.ena = 1'b0; f.ovf = 1'b0; f.serr = 1'b0;
    flag_q.push_back(f);
    pkt_q.delete(); asm_q.delete();
    pos = 0; rd_active = 0; cur_null = 1; wmode = 0; dropn = 0;
    m_null = 0; m_drop = 0;
  endtask

  task automatic add_pkt(input int len);
    src_t s;
    s.d = 8'h47; s.ps = 1'b1;
    src_q.push_back(s);
    for (int i = 1; i < len; i++) begin
      s.d = 8'($urandom); s.ps = 1'b0;
      src_q.push_back(s);
    end
  endtask

  task automatic add_junk(input int n);
    src_t s;
    for (int i = 0; i < n; i++) begin
      s.d = 8'($urandom); s.ps = 1'b0;
      src_q.push_back(s);
    end
  endtask

  // Monitor: compares DUT outputs with the model just after each edge.
  initial begin
    flag_t f;
    out_t  d;
    logic [7:0] last;
    last = 8'h00;
    forever begin
      @(posedge CLK);
      #1;
      if (flag_q.size() > 0) begin
        f = flag_q.pop_front();
        if (f.rst) begin
          check("reset_data_out", 32'(DATA_OUT), 32'h00);
          check("reset_ena_out", 32'(ENA_OUT), 32'h0);
          check("reset_psync_out", 32'(PSYNC_OUT), 32'h0);
          check("reset_overflow", 32'(OVERFLOW), 32'h0);
          check("reset_sync_err", 32'(SYNC_ERR), 32'h0);
          last = 8'h00;
        end else begin
          check("ena_out", 32'(ENA_OUT), 32'(f.ena));
          check("overflow", 32'(OVERFLOW), 32'(f.ovf));
          check("sync_err", 32'(SYNC_ERR), 32'(f.serr));
          if (ENA_OUT) begin
            if (data_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_byte at %0t: got %0h expected none", $time, DATA_OUT);
            end else begin
              d = data_q.pop_front();
              check("data_out", 32'(DATA_OUT), 32'(d.b));
              check("psync_out", 32'(PSYNC_OUT), 32'(d.ps));
              last = d.b;
            end
          end else begin
            check("data_hold", 32'(DATA_OUT), 32'(last));
            check("psync_idle", 32'(PSYNC_OUT), 32'h0);
          end
        end
      end
    end
  end

  initial begin
    src_t s;
    do_reset();
    do_reset();

    // Idle input: back-to-back null packets.
    repeat (400) tick(1'b1, 0);

    // Commit lands on the same cycle as a boundary with an empty buffer.
    for (int i = 0; i < 200 && pos != 1; i++) tick(1'b1, 0);
    add_pkt(PLEN);
    repeat (PLEN) tick(1'b1, 100);
    repeat (400) tick(1'b1, 0);

    // Known packet 47 40 64 10 followed by 0..183.
    s.ps = 1'b1; s.d = 8'h47; src_q.push_back(s);
    s.ps = 1'b0;
    s.d = 8'h40; src_q.push_back(s);
    s.d = 8'h64; src_q.push_back(s);
    s.d = 8'h10; src_q.push_back(s);
    for (int i = 0; i < 184; i++) begin s.d = 8'(i); src_q.push_back(s); end
    repeat (600) tick(1'b1, 70);

    // Overflow: five packets with the output stalled, then drain.
    repeat (5) add_pkt(PLEN);
    repeat (1000) tick(1'b0, 100);
    repeat (1100) tick(1'b1, 0);

    // Short packet aborted by a new sync byte.
    add_pkt(100);
    add_pkt(PLEN);
    repeat (700) tick(1'b1, 90);

    // OUT_EN toggling while data streams.
    repeat (6) begin add_junk(3); add_pkt(PLEN); end
    for (int i = 0; i < 2500; i++) tick(1'((i % 2) == 0), 60);

    // Reset in the middle of both an input and an output packet.
    add_pkt(PLEN);
    repeat (90) tick(1'b1, 100);
    do_reset();
    repeat (400) tick(1'b1, 80);

    // Random mix.
    for (int i = 0; i < 3000; i++) begin
      if (src_q.size() < 50) begin
        if ($urandom_range(9, 0) == 0) add_pkt(int'($urandom_range(187, 20)));
        else add_pkt(PLEN);
        if ($urandom_range(3, 0) == 0) add_junk(int'($urandom_range(5, 1)));
      end
      tick(1'($urandom_range(3, 0) != 0), int'($urandom_range(100, 20)));
    end

    // Drain everything still buffered.
    for (int i = 0; i < 3000 && (src_q.size() > 0 || pkt_q.size() > 0 || pos != 0); i++)
      tick(1'b1, 100);
    repeat (5) tick(1'b0, 0);
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    check("expected_bytes_left", 32'(data_q.size()), 32'd0);
`ifdef TS_STUFFER_STATS_EN
    check("null_cnt", NULL_CNT, 32'(m_null));
    check("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
